// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the ID/EX stage and its decoder.
//   - opcode / funct values of the supported instruction subset
//   - the nine 12-bit control words, bit order (MSB..LSB):
//     RegDst, ALUSrc[1:0], MemToReg, RegWr, MemWr, branch, jump[1:0],
//     ALUCntrl[1:0], jalr
//   - ID/EX FSM state encoding
//   - 16-to-32 bit sign-extension helper
package cpu_pkg;

   // Opcodes
   localparam logic [5:0] OP_RTYPE  = 6'd0;
   localparam logic [5:0] OP_BRANCH = 6'd1;
   localparam logic [5:0] OP_J      = 6'd2;
   localparam logic [5:0] OP_ADDI   = 6'd8;
   localparam logic [5:0] OP_LW     = 6'd35;
   localparam logic [5:0] OP_SW     = 6'd43;

   // R-type funct codes
   localparam logic [5:0] FN_JALR   = 6'd9;
   localparam logic [5:0] FN_NOR    = 6'd39;
   localparam logic [5:0] FN_SLT    = 6'd42;
   localparam logic [5:0] FN_SUBU   = 6'd35;

   // Control words
   localparam logic [11:0] CTRL_ADDI   = 12'b001010000100;
   localparam logic [11:0] CTRL_BRANCH = 12'b010000110100;
   localparam logic [11:0] CTRL_J      = 12'b000000001000;
   localparam logic [11:0] CTRL_LW     = 12'b001110000100;
   localparam logic [11:0] CTRL_SW     = 12'b001001000100;
   localparam logic [11:0] CTRL_JALR   = 12'b100010000001;
   localparam logic [11:0] CTRL_NOR    = 12'b100010000000;
   localparam logic [11:0] CTRL_SLT    = 12'b100010000010;
   localparam logic [11:0] CTRL_SUBU   = 12'b100010000110;
   localparam logic [11:0] CTRL_NONE   = 12'b000000000000;

   // Bit positions inside the control word
   localparam int CTRL_REGDST_BIT = 11;
   localparam int CTRL_REGWR_BIT  = 7;

   // ID/EX FSM: RUN = normal flow, BUBBLE = EX holds a load-use bubble
   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } stage_state_e;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decoder for the ID stage.
// Ports:
//   instr    in  32  instruction to decode
//   control  out 12  control word (0 for undefined opcode/funct)
//   illegal  out 1   instruction has an undefined opcode/funct
//   dest_reg out 5   write-back register (0 when RegWr is clear)
//   imm      out 32  sign-extended instr[15:0]
//   rs_used  out 1   instr[25:21] is a source operand
//   rt_used  out 1   instr[20:16] is a source operand
module ctrl_decode
   import cpu_pkg::*;
(
   input  logic [31:0] instr,
   output logic [11:0] control,
   output logic        illegal,
   output logic [4:0]  dest_reg,
   output logic [31:0] imm,
   output logic        rs_used,
   output logic        rt_used
);

   logic [5:0] opcode;
   logic [5:0] funct;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];

   always_comb begin
      control = CTRL_NONE;
      illegal = 1'b0;
      case (opcode)
         OP_ADDI:   control = CTRL_ADDI;
         OP_BRANCH: control = CTRL_BRANCH;
         OP_J:      control = CTRL_J;
         OP_LW:     control = CTRL_LW;
         OP_SW:     control = CTRL_SW;
         OP_RTYPE: begin
            case (funct)
               FN_JALR: control = CTRL_JALR;
               FN_NOR:  control = CTRL_NOR;
               FN_SLT:  control = CTRL_SLT;
               FN_SUBU: control = CTRL_SUBU;
               default: illegal = 1'b1;
            endcase
         end
         default:   illegal = 1'b1;
      endcase
   end

   // Non-writing instructions report register 0 so the hazard check
   // never matches against them.
   always_comb begin
      dest_reg = 5'd0;
      if (control[CTRL_REGWR_BIT]) begin
         if (control[CTRL_REGDST_BIT]) dest_reg = instr[15:11];
         else                          dest_reg = instr[20:16];
      end
   end

   assign imm = sext16(instr[15:0]);

   // Source-field usage is a function of the opcode alone, legal or not.
   assign rs_used = (opcode != OP_J);
   assign rt_used = (opcode == OP_RTYPE) || (opcode == OP_SW);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   instrIn, pc8In, validIn IF/ID slot contents
//   rsData, rtData          register-file data for instrIn rs / rt
//   flush                   redirect: the instruction entering EX is killed
//   hold                    downstream freeze: every register keeps its value
//   control .. illegal      registered EX slot contents
//   stall                   combinational IF/ID + fetch hold request
//   bubbleCnt               saturating count of load-use bubbles inserted
//   fsmState                debug view of the FSM (0 = RUN, 1 = BUBBLE)
//
// Flow control: the producer (IF/ID) offers validIn every cycle; when
// stall is high the producer must keep presenting the same instruction,
// and the stage loads either a bubble (hazard) or nothing (hold). When
// stall is low the offered instruction is taken on the next rising edge.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      instrIn,
   input  logic [31:0]      pc8In,
   input  logic             validIn,
   input  logic [31:0]      rsData,
   input  logic [31:0]      rtData,
   input  logic             flush,
   input  logic             hold,
   output logic [11:0]      control,
   output logic [31:0]      instrOut,
   output logic [31:0]      pc8Out,
   output logic [31:0]      rsOut,
   output logic [31:0]      rtOut,
   output logic [31:0]      immOut,
   output logic [4:0]       destReg,
   output logic             validOut,
   output logic             illegal,
   output logic             stall,
   output logic [CNT_W-1:0] bubbleCnt,
   output logic             fsmState
);

   // Decoder outputs for the instruction in IF/ID
   logic [11:0] dec_control;
   logic        dec_illegal;
   logic [4:0]  dec_dest;
   logic [31:0] dec_imm;
   logic        dec_rs_used;
   logic        dec_rt_used;

   ctrl_decode u_decode (
      .instr    (instrIn),
      .control  (dec_control),
      .illegal  (dec_illegal),
      .dest_reg (dec_dest),
      .imm      (dec_imm),
      .rs_used  (dec_rs_used),
      .rt_used  (dec_rt_used)
   );

   // Stage registers
   logic [11:0]      control_q,  control_d;
   logic [31:0]      instr_q,    instr_d;
   logic [31:0]      pc8_q,      pc8_d;
   logic [31:0]      rs_q,       rs_d;
   logic [31:0]      rt_q,       rt_d;
   logic [31:0]      imm_q,      imm_d;
   logic [4:0]       dest_q,     dest_d;
   logic             valid_q,    valid_d;
   logic             illegal_q,  illegal_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   stage_state_e     state_q,    state_d;

   // Load-use hazard: EX holds a valid load whose destination is read
   // by the instruction waiting in IF/ID.
   logic ex_is_load;
   logic rs_hit;
   logic rt_hit;
   logic hazard;

   assign ex_is_load = valid_q && (instr_q[31:26] == OP_LW) && (dest_q != 5'd0);
   assign rs_hit     = dec_rs_used && (instrIn[25:21] == dest_q);
   assign rt_hit     = dec_rt_used && (instrIn[20:16] == dest_q);
   assign hazard     = validIn && ex_is_load && (rs_hit || rt_hit);

   // A flush discards the dependent instruction anyway, so it never stalls.
   assign stall = hold || (hazard && !flush);

   // Register next-state: hold > flush > hazard > normal load
   always_comb begin
      control_d = control_q;
      instr_d   = instr_q;
      pc8_d     = pc8_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      imm_d     = imm_q;
      dest_d    = dest_q;
      valid_d   = valid_q;
      illegal_d = illegal_q;
      cnt_d     = cnt_q;
      if (!hold) begin
         if (flush || hazard || !validIn) begin
            control_d = CTRL_NONE;
            instr_d   = 32'd0;
            pc8_d     = 32'd0;
            rs_d      = 32'd0;
            rt_d      = 32'd0;
            imm_d     = 32'd0;
            dest_d    = 5'd0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            // Only bubbles inserted for load-use count; saturate at all-ones.
            if (hazard && !flush && (cnt_q != {CNT_W{1'b1}})) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            control_d = dec_control;
            instr_d   = instrIn;
            pc8_d     = pc8In;
            rs_d      = rsData;
            rt_d      = rtData;
            imm_d     = dec_imm;
            dest_d    = dec_dest;
            valid_d   = 1'b1;
            illegal_d = dec_illegal;
         end
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:    if (hazard && !flush && !hold) state_d = ST_BUBBLE;
         ST_BUBBLE: if (!hold)                     state_d = ST_RUN;
         default:                                  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         control_q <= CTRL_NONE;
         instr_q   <= 32'd0;
         pc8_q     <= 32'd0;
         rs_q      <= 32'd0;
         rt_q      <= 32'd0;
         imm_q     <= 32'd0;
         dest_q    <= 5'd0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
         state_q   <= ST_RUN;
      end else begin
         control_q <= control_d;
         instr_q   <= instr_d;
         pc8_q     <= pc8_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         imm_q     <= imm_d;
         dest_q    <= dest_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
      end
   end

   assign control   = control_q;
   assign instrOut  = instr_q;
   assign pc8Out    = pc8_q;
   assign rsOut     = rs_q;
   assign rtOut     = rt_q;
   assign immOut    = imm_q;
   assign destReg   = dest_q;
   assign validOut  = valid_q;
   assign illegal   = illegal_q;
   assign bubbleCnt = cnt_q;
   assign fsmState  = state_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic for
// id_ex_stage, checked every cycle against a behavioural model of the
// EX slot, with hand-computed literal expectations for key scenarios.
module tb_id_ex_stage;

   localparam int CW = 4;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUT ----------------
   logic [31:0]   instrIn, pc8In, rsData, rtData;
   logic          validIn, flush, hold;
   logic [11:0]   control;
   logic [31:0]   instrOut, pc8Out, rsOut, rtOut, immOut;
   logic [4:0]    destReg;
   logic          validOut, illegal, stall, fsmState;
   logic [CW-1:0] bubbleCnt;

   id_ex_stage #(.CNT_W(CW)) dut (
      .clock(clock), .reset(reset),
      .instrIn(instrIn), .pc8In(pc8In), .validIn(validIn),
      .rsData(rsData), .rtData(rtData), .flush(flush), .hold(hold),
      .control(control), .instrOut(instrOut), .pc8Out(pc8Out),
      .rsOut(rsOut), .rtOut(rtOut), .immOut(immOut), .destReg(destReg),
      .validOut(validOut), .illegal(illegal), .stall(stall),
      .bubbleCnt(bubbleCnt), .fsmState(fsmState)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Decode table taken straight from the instruction list: {illegal, control}
   function automatic logic [12:0] ref_decode(input logic [31:0] i);
      case (i[31:26])
         6'd8:    return {1'b0, 12'b001010000100};
         6'd1:    return {1'b0, 12'b010000110100};
         6'd2:    return {1'b0, 12'b000000001000};
         6'd35:   return {1'b0, 12'b001110000100};
         6'd43:   return {1'b0, 12'b001001000100};
         6'd0: begin
            case (i[5:0])
               6'd9:    return {1'b0, 12'b100010000001};
               6'd39:   return {1'b0, 12'b100010000000};
               6'd42:   return {1'b0, 12'b100010000010};
               6'd35:   return {1'b0, 12'b100010000110};
               default: return {1'b1, 12'b0};
            endcase
         end
         default: return {1'b1, 12'b0};
      endcase
   endfunction

   function automatic logic [4:0] ref_dest(input logic [31:0] i, input logic [11:0] c);
      if (!c[7]) return 5'd0;
      return c[11] ? i[15:11] : i[20:16];
   endfunction

   typedef struct {
      logic [11:0] ctrl;
      logic [31:0] instr, pc8, rs, rt, imm;
      logic [4:0]  dest;
      logic        valid, ill;
   } ex_t;

   ex_t           m;
   logic [CW-1:0] m_cnt;
   logic          m_bub;

   // Does the instruction offered by IF/ID read the register the EX load writes?
   function automatic logic ref_hazard();
      logic [5:0] op;
      logic       uses_rs, uses_rt;
      op = instrIn[31:26];
      uses_rs = (op != 6'd2);
      uses_rt = (op == 6'd0) || (op == 6'd43);
      if (!(validIn && m.valid && m.instr[31:26] == 6'd35 && m.dest != 5'd0)) return 1'b0;
      return (uses_rs && instrIn[25:21] == m.dest) || (uses_rt && instrIn[20:16] == m.dest);
   endfunction

   always @(posedge clock or negedge reset) begin
      logic       haz;
      logic [12:0] dec;
      if (!reset) begin
         m     = '{ctrl: '0, instr: '0, pc8: '0, rs: '0, rt: '0, imm: '0, dest: '0, valid: 1'b0, ill: 1'b0};
         m_cnt = '0;
         m_bub = 1'b0;
      end else if (!hold) begin
         haz   = ref_hazard();
         m_bub = haz && !flush;
         if (flush || haz || !validIn) begin
            m = '{ctrl: '0, instr: '0, pc8: '0, rs: '0, rt: '0, imm: '0, dest: '0, valid: 1'b0, ill: 1'b0};
         end else begin
            dec = ref_decode(instrIn);
            m.ctrl  = dec[11:0];
            m.ill   = dec[12];
            m.instr = instrIn;
            m.pc8   = pc8In;
            m.rs    = rsData;
            m.rt    = rtData;
            m.imm   = {{16{instrIn[15]}}, instrIn[15:0]};
            m.dest  = ref_dest(instrIn, dec[11:0]);
            m.valid = 1'b1;
         end
         if (haz && !flush && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic prev_stall = 1'b0;

   always @(negedge clock) begin
      if (reset === 1'b1) begin
         chk("m_control",  {20'd0, control},   {20'd0, m.ctrl});
         chk("m_instrOut", instrOut,           m.instr);
         chk("m_pc8Out",   pc8Out,             m.pc8);
         chk("m_rsOut",    rsOut,              m.rs);
         chk("m_rtOut",    rtOut,              m.rt);
         chk("m_immOut",   immOut,             m.imm);
         chk("m_destReg",  {27'd0, destReg},   {27'd0, m.dest});
         chk("m_validOut", {31'd0, validOut},  {31'd0, m.valid});
         chk("m_illegal",  {31'd0, illegal},   {31'd0, m.ill});
         chk("m_bubbleCnt", 32'(bubbleCnt),    32'(m_cnt));
         chk("m_fsmState", {31'd0, fsmState},  {31'd0, m_bub});
         chk("m_stall",    {31'd0, stall},     {31'd0, hold | (ref_hazard() & ~flush)});
      end
      prev_stall = stall;
   end

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic [31:0] i, input logic v, input logic [31:0] rs,
                         input logic [31:0] rt, input logic fl, input logic ho);
      instrIn = i;
      pc8In   = 32'h0040_0000 + {i[7:0], 2'b00};
      validIn = v;
      rsData  = rs;
      rtData  = rt;
      flush   = fl;
      hold    = ho;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd;
      logic [15:0] low;
      case ($urandom_range(0, 7))
         0:       op = 6'd0;
         1:       op = 6'd1;
         2:       op = 6'd2;
         3:       op = 6'd8;
         4, 5:    op = 6'd35;
         6:       op = 6'd43;
         default: op = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 5))
         0:       fn = 6'd9;
         1:       fn = 6'd39;
         2:       fn = 6'd42;
         3:       fn = 6'd35;
         4:       fn = 6'd13;
         default: fn = 6'($urandom_range(0, 63));
      endcase
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      if (op == 6'd0) low = {rd, 5'd0, fn};
      else            low = 16'($urandom_range(0, 65535));
      return {op, rs, rt, low};
   endfunction

   // ---------------- stimulus ----------------
   localparam logic [31:0] LW5   = 32'h8C25_0000; // lw   $5,0($1)
   localparam logic [31:0] SUBU  = 32'h00A2_3023; // subu $6,$5,$2
   localparam logic [31:0] SW5   = 32'hAC65_0004; // sw   $5,4($3)
   localparam logic [31:0] LW0   = 32'h8C20_0000; // lw   $0,0($1)
   localparam logic [31:0] ADDI0 = 32'h2007_0001; // addi $7,$0,1

   initial begin
      logic [CW-1:0] cnt_before;

      set_in(32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      #12;
      // reset state
      chk("rst_control",  {20'd0, control}, 32'd0);
      chk("rst_validOut", {31'd0, validOut}, 32'd0);
      chk("rst_bubbleCnt", 32'(bubbleCnt), 32'd0);
      chk("rst_stall",    {31'd0, stall}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      tick();

      // load-use on rs: one bubble, then subu with refreshed operand
      set_in(LW5, 1'b1, 32'h11, 32'h12, 1'b0, 1'b0);
      tick();
      set_in(SUBU, 1'b1, 32'hAAAA, 32'h2222, 1'b0, 1'b0);
      #1 chk("lu_stall", {31'd0, stall}, 32'd1);
      tick();
      chk("lu_cnt",      32'(bubbleCnt), 32'd1);
      chk("lu_bubble_v", {31'd0, validOut}, 32'd0);
      chk("lu_state",    {31'd0, fsmState}, 32'd1);
      rsData = 32'h5555_0001;
      #1 chk("lu_stall_off", {31'd0, stall}, 32'd0);
      tick();
      chk("lu_ctrl",  {20'd0, control}, 32'h886);
      chk("lu_rs",    rsOut, 32'h5555_0001);
      chk("lu_dest",  {27'd0, destReg}, 32'd6);
      chk("lu_state_run", {31'd0, fsmState}, 32'd0);

      // load-use on rt through a store; $0 destination never stalls
      set_in(LW5, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
      tick();
      set_in(SW5, 1'b1, 32'h3, 32'h4, 1'b0, 1'b0);
      #1 chk("sw_stall", {31'd0, stall}, 32'd1);
      tick();
      chk("sw_cnt", 32'(bubbleCnt), 32'd2);
      tick();
      chk("sw_valid", {31'd0, validOut}, 32'd1);
      chk("sw_dest",  {27'd0, destReg}, 32'd0);
      set_in(LW0, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
      tick();
      set_in(ADDI0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      #1 chk("zero_nostall", {31'd0, stall}, 32'd0);
      tick();
      chk("zero_dest", {27'd0, destReg}, 32'd7);

      // hazard together with flush
      set_in(LW5, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
      tick();
      cnt_before = bubbleCnt;
      set_in(SUBU, 1'b1, 32'h9, 32'h8, 1'b1, 1'b0);
      #1 chk("fl_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("fl_valid", {31'd0, validOut}, 32'd0);
      chk("fl_cnt",   32'(bubbleCnt), 32'(cnt_before));
      chk("fl_state", {31'd0, fsmState}, 32'd0);

      // hold for three cycles while in BUBBLE
      set_in(LW5, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
      tick();
      set_in(SUBU, 1'b1, 32'h9, 32'h8, 1'b0, 1'b0);
      tick();
      cnt_before = bubbleCnt;
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 chk("hd_stall", {31'd0, stall}, 32'd1);
         tick();
         chk("hd_state", {31'd0, fsmState}, 32'd1);
         chk("hd_valid", {31'd0, validOut}, 32'd0);
         chk("hd_cnt",   32'(bubbleCnt), 32'(cnt_before));
      end
      hold = 1'b0;
      tick();
      chk("hd_run",  {31'd0, fsmState}, 32'd0);
      chk("hd_ctrl", {20'd0, control}, 32'h886);

      // undefined instructions and sign extension
      set_in(32'hFC00_0000, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      chk("il63_ctrl", {20'd0, control}, 32'd0);
      chk("il63_ill",  {31'd0, illegal}, 32'd1);
      chk("il63_dest", {27'd0, destReg}, 32'd0);
      set_in(32'h0000_400D, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      chk("ilfn_ctrl", {20'd0, control}, 32'd0);
      chk("ilfn_ill",  {31'd0, illegal}, 32'd1);
      chk("ilfn_dest", {27'd0, destReg}, 32'd0);
      set_in(32'h2023_FFFF, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      chk("addi_imm",  immOut, 32'hFFFF_FFFF);
      chk("addi_dest", {27'd0, destReg}, 32'd3);
      chk("addi_ill",  {31'd0, illegal}, 32'd0);

      // saturate the bubble counter
      for (int k = 0; k < 20; k++) begin
         set_in(LW5, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
         tick();
         set_in(SUBU, 1'b1, 32'h3, 32'h4, 1'b0, 1'b0);
         tick();
         tick();
      end
      chk("sat_cnt", 32'(bubbleCnt), 32'(4'hF));

      // randomized traffic; a stalled IF/ID keeps presenting its instruction
      for (int k = 0; k < 3000; k++) begin
         if (!prev_stall) begin
            instrIn = rand_instr();
            pc8In   = $urandom();
            validIn = ($urandom_range(0, 9) != 0);
         end
         rsData = $urandom();
         rtData = $urandom();
         flush  = ($urandom_range(0, 9) == 0);
         hold   = ($urandom_range(0, 9) == 0);
         tick();
      end

      // reset in the middle of a stall, away from any clock edge
      set_in(LW5, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
      tick();
      set_in(SUBU, 1'b1, 32'h3, 32'h4, 1'b0, 1'b0);
      #1 chk("mr_stall_before", {31'd0, stall}, 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("mr_control",  {20'd0, control}, 32'd0);
      chk("mr_instrOut", instrOut, 32'd0);
      chk("mr_validOut", {31'd0, validOut}, 32'd0);
      chk("mr_bubbleCnt", 32'(bubbleCnt), 32'd0);
      chk("mr_state",    {31'd0, fsmState}, 32'd0);
      chk("mr_stall",    {31'd0, stall}, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
